pool_output_sequencer: RTL and testbench
========================================

Name: pool_output_sequencer

Overview:
- Schedules the 8-bit pooled-output stream from the max-pooling stage into the output-SRAM packing writer.
- Handles the `dut_run` / `dut_busy` handshake and takes a per-matrix byte count from the configuration interface.
- Drives the writer's 2-bit valid code: 1 = data byte, 2 = final odd byte (writer zero-pads the LSB), 3 = write-address reset.
- Back-pressures the pooling stage so every write-gap the packer requires is honoured.

Parameters:
- DATA_W, 8, pooled data width.
- CNT_W, 12, width of the per-matrix byte count and the remaining-byte counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_b  in  1  asynchronous, active-high reset.
- dut_run  in  1  start request; sampled only in IDLE.
- dut_busy  out  1  high from run acceptance until the DONE cycle inclusive.
- cfg_valid  in  1  per-matrix configuration strobe.
- cfg_count  in  CNT_W  number of pooled bytes in this matrix.
- cfg_last  in  1  this matrix is the final one of the run.
- cfg_ready  out  1  high only in WAIT_CFG.
- pool_valid  in  1  pooled byte available.
- pool_data  in  DATA_W  pooled byte.
- pool_ready  out  1  sequencer accepts a byte this cycle.
- wr_valid  out  2  valid code to the packing writer.
- wr_data  out  DATA_W  byte to the packing writer.
- matrix_done  out  1  one-cycle pulse after the last byte of a matrix is issued.
- all_done  out  1  one-cycle pulse in DONE.

Behaviour:
- Reset: state=IDLE. `dut_busy`, `cfg_ready`, `pool_ready`, `matrix_done` and `all_done` are 0. `wr_valid`=0, `wr_data`=0. All counters are cleared. Reset asserted mid-operation aborts immediately with no flush code emitted.
- Outputs `wr_valid`, `wr_data`, `matrix_done` and `all_done` are registered. `pool_ready` and `cfg_ready` are combinational from state and counters.
- FSM states: IDLE, WAIT_CFG, STREAM, GAP, FLUSH, DONE.
- IDLE: when `dut_run`=1, go to WAIT_CFG and set `dut_busy`=1 next cycle.
- WAIT_CFG: `cfg_ready`=1. When `cfg_valid`=1:
  - latch `cfg_count` into `remaining`, latch `cfg_last`, clear `pair_phase`;
  - if `cfg_count`=0: go to FLUSH when `cfg_last`=1, otherwise stay in WAIT_CFG. No `matrix_done` pulse for a zero-count matrix.
  - otherwise go to STREAM.
- STREAM: `pool_ready`=1. A byte is accepted when `pool_valid` and `pool_ready` are both 1. On acceptance:
  - next cycle `wr_data`=`pool_data` and `wr_valid`=1;
  - exception: if `remaining`=1 and `pair_phase`=0 (odd final byte), `wr_valid`=2;
  - decrement `remaining` and toggle `pair_phase`.
- STREAM transitions:
  - after accepting the second byte of a pair, or an odd final byte, go to GAP;
  - otherwise stay in STREAM.
  - A cycle with no acceptance emits `wr_valid`=0. `wr_data` holds its last value.
- GAP: exactly 1 cycle. `pool_ready`=0, `wr_valid`=0. This cycle lets the writer commit the packed word.
  - If `remaining`=0: pulse `matrix_done` next cycle, then go to FLUSH if the latched last flag is set, else to WAIT_CFG.
  - Otherwise return to STREAM.
- FLUSH: emit `wr_valid`=3 for one cycle, then go to DONE.
- DONE: pulse `all_done`, drop `dut_busy` on the next edge, go to IDLE.
- Ignored inputs:
  - `dut_run` outside IDLE;
  - `cfg_valid` outside WAIT_CFG;
  - `pool_valid` while `pool_ready`=0 (data is held upstream, not lost).
- Simultaneous `cfg_valid` and `pool_valid` in WAIT_CFG: only the configuration is taken; the byte waits.
- `remaining` never wraps; underflow is impossible by construction.
- Minimum cycles per matrix of N bytes: N + ceil(N/2).

Test Plan:
- Run with one matrix, `cfg_count`=4, `cfg_last`=1, `pool_valid` held high:
  - `wr_valid` sequence is 1,1,0,1,1,0,3;
  - `pool_ready` is low on each GAP cycle;
  - `matrix_done` pulses once, `all_done` pulses once, `dut_busy` returns to 0.
- `cfg_count`=3, `pool_data` sequence A1,B2,C3:
  - `wr_valid` 1,1,0,2,0;
  - `wr_data` is C3 together with code 2.
- Two matrices (count 2, `cfg_last`=0; then count 1, `cfg_last`=1):
  - two `matrix_done` pulses;
  - code 3 appears only after the second matrix.
- `pool_valid` toggling 1,0,1,0 with `cfg_count`=2:
  - `wr_valid`=0 on idle cycles;
  - the byte count remains correct and there is a single GAP after the second byte.
- `cfg_count`=0 with `cfg_last`=1:
  - no data codes, no `matrix_done`;
  - go directly to FLUSH (code 3), then `all_done`.
- Assert `reset_b` in STREAM after 1 of 4 bytes:
  - all outputs go to 0 asynchronously, state returns to IDLE;
  - a new `dut_run` behaves as in the first scenario.

Source files
------------

// File: rtl/pool_output_sequencer.sv
// Pooled-output sequencer: paces the 8-bit max-pool stream into the
// output-SRAM packing writer. It inserts the one-cycle commit gap after
// every byte pair or odd final byte, and emits the address-reset code once
// the last matrix of a run has been written.
module pool_output_sequencer #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 12
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              dut_run,
  output logic              dut_busy,
  input  logic              cfg_valid,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic              cfg_last,
  output logic              cfg_ready,
  input  logic              pool_valid,
  input  logic [DATA_W-1:0] pool_data,
  output logic              pool_ready,
  output logic [1:0]        wr_valid,
  output logic [DATA_W-1:0] wr_data,
  output logic              matrix_done,
  output logic              all_done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_CFG = 3'd1,
    STREAM   = 3'd2,
    GAP      = 3'd3,
    FLUSH    = 3'd4,
    DONE     = 3'd5
  } state_t;

  // Writer valid codes
  localparam logic [1:0] WV_NONE  = 2'd0;
  localparam logic [1:0] WV_BYTE  = 2'd1;
  localparam logic [1:0] WV_ODD   = 2'd2;
  localparam logic [1:0] WV_RESET = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t              state_q;
  logic [CNT_W-1:0]    remaining_q;
  logic                pair_phase_q;   // 1 = next accepted byte completes a pair
  logic                last_q;         // latched cfg_last of the current matrix
  logic                busy_q;
  logic [1:0]          wr_valid_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic                matrix_done_q;
  logic                all_done_q;

  logic                accept;
  logic                final_byte;

  // Handshake readies depend only on state, so the pooling stage sees
  // back-pressure in the same cycle the FSM enters GAP.
  always_comb begin
    cfg_ready  = (state_q == WAIT_CFG);
    pool_ready = (state_q == STREAM);
    accept     = pool_valid && (state_q == STREAM);
    final_byte = (remaining_q == CNT_ONE);
  end

  // Sequencer FSM with registered writer-side outputs.
  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      state_q       <= IDLE;
      remaining_q   <= CNT_ZERO;
      pair_phase_q  <= 1'b0;
      last_q        <= 1'b0;
      busy_q        <= 1'b0;
      wr_valid_q    <= WV_NONE;
      wr_data_q     <= '0;
      matrix_done_q <= 1'b0;
      all_done_q    <= 1'b0;
    end else begin
      // Codes and pulses last one cycle unless re-asserted below.
      wr_valid_q    <= WV_NONE;
      matrix_done_q <= 1'b0;
      all_done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dut_run) begin
            busy_q  <= 1'b1;
            state_q <= WAIT_CFG;
          end
        end
        WAIT_CFG: begin
          if (cfg_valid) begin
            remaining_q  <= cfg_count;
            last_q       <= cfg_last;
            pair_phase_q <= 1'b0;
            if (cfg_count == CNT_ZERO) begin
              // Empty matrix: nothing to write and no matrix_done.
              if (cfg_last) begin
                state_q <= FLUSH;
              end
            end else begin
              state_q <= STREAM;
            end
          end
        end
        STREAM: begin
          if (accept) begin
            wr_data_q    <= pool_data;
            // A lone trailing byte tells the writer to zero-pad the word.
            wr_valid_q   <= (final_byte && !pair_phase_q) ? WV_ODD : WV_BYTE;
            remaining_q  <= remaining_q - CNT_ONE;
            pair_phase_q <= ~pair_phase_q;
            if (pair_phase_q || final_byte) begin
              state_q <= GAP;
            end
          end
        end
        GAP: begin
          if (remaining_q == CNT_ZERO) begin
            matrix_done_q <= 1'b1;
            state_q       <= last_q ? FLUSH : WAIT_CFG;
          end else begin
            state_q <= STREAM;
          end
        end
        FLUSH: begin
          // Address-reset code and all_done both appear during DONE.
          wr_valid_q <= WV_RESET;
          all_done_q <= 1'b1;
          state_q    <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dut_busy    = busy_q;
  assign wr_valid    = wr_valid_q;
  assign wr_data     = wr_data_q;
  assign matrix_done = matrix_done_q;
  assign all_done    = all_done_q;

endmodule

// File: tb/tb_pool_output_sequencer.sv
// Directed bench for pool_output_sequencer. Inputs change 1 time unit after
// the rising edge; outputs are checked at the same point, after they settle.
module tb_pool_output_sequencer;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 12;

  logic              clk;
  logic              reset_b;
  logic              dut_run;
  logic              dut_busy;
  logic              cfg_valid;
  logic [CNT_W-1:0]  cfg_count;
  logic              cfg_last;
  logic              cfg_ready;
  logic              pool_valid;
  logic [DATA_W-1:0] pool_data;
  logic              pool_ready;
  logic [1:0]        wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              matrix_done;
  logic              all_done;

  int total_cnt = 0;
  int pass_cnt  = 0;

  pool_output_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .dut_run    (dut_run),
    .dut_busy   (dut_busy),
    .cfg_valid  (cfg_valid),
    .cfg_count  (cfg_count),
    .cfg_last   (cfg_last),
    .cfg_ready  (cfg_ready),
    .pool_valid (pool_valid),
    .pool_data  (pool_data),
    .pool_ready (pool_ready),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .matrix_done(matrix_done),
    .all_done   (all_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Checks the control/status outputs of one cycle.
  task automatic outs(input string tag, input logic [1:0] wv, input logic pr,
                      input logic cr, input logic md, input logic ad, input logic bz);
    chk({tag, ".wr_valid"},    {6'd0, wr_valid}, {6'd0, wv});
    chk({tag, ".pool_ready"},  {7'd0, pool_ready}, {7'd0, pr});
    chk({tag, ".cfg_ready"},   {7'd0, cfg_ready}, {7'd0, cr});
    chk({tag, ".matrix_done"}, {7'd0, matrix_done}, {7'd0, md});
    chk({tag, ".all_done"},    {7'd0, all_done}, {7'd0, ad});
    chk({tag, ".dut_busy"},    {7'd0, dut_busy}, {7'd0, bz});
    $display("step %s: wr_valid=%0d wr_data=%02h pool_ready=%0b cfg_ready=%0b md=%0b ad=%0b busy=%0b",
             tag, wr_valid, wr_data, pool_ready, cfg_ready, matrix_done, all_done, dut_busy);
  endtask

  // Starts a run and presents one configuration on the same cycle.
  task automatic start(input logic [CNT_W-1:0] cnt, input logic last);
    dut_run = 1'b1; cfg_valid = 1'b1; cfg_count = cnt; cfg_last = last;
    tick();
    dut_run = 1'b0;
  endtask

  // One matrix of 4 bytes, last, with pool_valid held high.
  task automatic run_four(input string pfx);
    pool_valid = 1'b1; pool_data = 8'h10;
    start(12'd4, 1'b1);
    outs({pfx, "1"}, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(); cfg_valid = 1'b0;
    outs({pfx, "2"}, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    outs({pfx, "3"}, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk({pfx, "3.wr_data"}, wr_data, 8'h10);
    pool_data = 8'h11;
    tick();
    outs({pfx, "4"}, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk({pfx, "4.wr_data"}, wr_data, 8'h11);
    pool_data = 8'h12;
    tick();
    outs({pfx, "5"}, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    outs({pfx, "6"}, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk({pfx, "6.wr_data"}, wr_data, 8'h12);
    pool_data = 8'h13;
    tick();
    outs({pfx, "7"}, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk({pfx, "7.wr_data"}, wr_data, 8'h13);
    tick();
    outs({pfx, "8"}, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    outs({pfx, "9"}, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    outs({pfx, "10"}, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pool_valid = 1'b0;
  endtask

  initial begin
    reset_b = 1'b1; dut_run = 1'b0; cfg_valid = 1'b0; cfg_count = '0;
    cfg_last = 1'b0; pool_valid = 1'b0; pool_data = '0;
    tick();
    outs("rst", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.wr_data", wr_data, 8'h00);
    reset_b = 1'b0;
    tick();
    outs("idle", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Four bytes, pool_valid held high
    run_four("a");

    // Three bytes: odd final byte gets code 2
    pool_valid = 1'b1; pool_data = 8'hA1;
    start(12'd3, 1'b1);
    outs("b1", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(); cfg_valid = 1'b0;
    outs("b2", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    outs("b3", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("b3.wr_data", wr_data, 8'hA1);
    pool_data = 8'hB2;
    tick();
    outs("b4", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("b4.wr_data", wr_data, 8'hB2);
    pool_data = 8'hC3;
    tick();
    outs("b5", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    outs("b6", 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("b6.wr_data", wr_data, 8'hC3);
    tick();
    outs("b7", 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    outs("b8", 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    outs("b9", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pool_valid = 1'b0;

    // Two matrices: 2 bytes (not last) then 1 byte (last)
    pool_valid = 1'b1; pool_data = 8'h21;
    start(12'd2, 1'b0);
    outs("c1", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(); cfg_valid = 1'b0;
    outs("c2", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    outs("c3", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("c3.wr_data", wr_data, 8'h21);
    pool_data = 8'h22;
    tick();
    outs("c4", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("c4.wr_data", wr_data, 8'h22);
    pool_data = 8'h23;
    tick();
    outs("c5", 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    // Configuration and a pending byte together: only the config is taken
    cfg_valid = 1'b1; cfg_count = 12'd1; cfg_last = 1'b1;
    tick(); cfg_valid = 1'b0;
    outs("c6", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("c6.wr_data", wr_data, 8'h22);
    tick();
    outs("c7", 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("c7.wr_data", wr_data, 8'h23);
    tick();
    outs("c8", 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    outs("c9", 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    outs("c10", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pool_valid = 1'b0;

    // pool_valid toggling with two bytes
    start(12'd2, 1'b1);
    outs("d1", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(); cfg_valid = 1'b0;
    outs("d2", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    pool_valid = 1'b1; pool_data = 8'h31;
    tick();
    outs("d3", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("d3.wr_data", wr_data, 8'h31);
    pool_valid = 1'b0; pool_data = 8'h99;
    tick();
    outs("d4", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("d4.wr_data", wr_data, 8'h31);
    pool_valid = 1'b1; pool_data = 8'h32;
    tick();
    outs("d5", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("d5.wr_data", wr_data, 8'h32);
    pool_valid = 1'b0;
    tick();
    outs("d6", 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    outs("d7", 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    outs("d8", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Zero-count last matrix goes straight to FLUSH
    start(12'd0, 1'b1);
    outs("e1", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(); cfg_valid = 1'b0;
    outs("e2", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    outs("e3", 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    outs("e4", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset after one of four bytes, then a clean rerun
    pool_valid = 1'b1; pool_data = 8'h55;
    start(12'd4, 1'b1);
    tick(); cfg_valid = 1'b0;
    tick();
    outs("f3", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    #2 reset_b = 1'b1;
    #1;
    outs("f_rst", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("f_rst.wr_data", wr_data, 8'h00);
    pool_valid = 1'b0;
    tick();
    reset_b = 1'b0;
    tick();
    outs("f_idle", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_four("g");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
